// File: rtl/paint_pixel_datapath_pkg.sv
// Shared constants, state encoding, pixel payload and coordinate clamps
// for the paint pixel datapath.
package paint_pixel_datapath_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned XW       = 8;
  localparam int unsigned YW       = 7;
  localparam int unsigned CW       = 3;
  localparam int unsigned DW       = 8;

  localparam logic [1:0] MODE_NONE    = 2'b00;
  localparam logic [1:0] MODE_FILL    = 2'b01;
  localparam logic [1:0] MODE_OUTLINE = 2'b10;
  localparam logic [1:0] MODE_POINT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_POINT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;
  } pixel_t;

  function automatic logic [XW-1:0] clamp_x(input logic [DW-1:0] d);
    return (d > DW'(SCREEN_W - 1)) ? XW'(SCREEN_W - 1) : XW'(d);
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] d);
    return (d > YW'(SCREEN_H - 1)) ? YW'(SCREEN_H - 1) : d;
  endfunction

endpackage

// File: rtl/paint_pixel_datapath_if.sv
// Control/pixel bus between the paint FSM (master) and the pixel datapath (slave).
interface paint_pixel_datapath_if;
  import paint_pixel_datapath_pkg::*;

  logic [DW-1:0] data_in;
  logic [CW-1:0] colour_in;
  logic          loadX;
  logic          loadY;
  logic          loadX2;
  logic          loadY2;
  logic          loadC;
  logic          enable;
  logic [1:0]    alu_select;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] colour_out;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output data_in, colour_in, loadX, loadY, loadX2, loadY2, loadC, enable, alu_select,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    input  data_in, colour_in, loadX, loadY, loadX2, loadY2, loadC, enable, alu_select,
    output x_out, y_out, colour_out, plot, busy, done
  );

endinterface

// File: rtl/paint_pixel_datapath_raster_scan_counter.sv
// Raster x/y walker over a latched rectangle; exposes the position it will
// move to this cycle so the caller can register that pixel directly.
module paint_pixel_datapath_raster_scan_counter
  import paint_pixel_datapath_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic [XW-1:0] xmin_in,
  input  logic [XW-1:0] xmax_in,
  input  logic [YW-1:0] ymin_in,
  input  logic [YW-1:0] ymax_in,
  output logic [XW-1:0] x_nxt_c,
  output logic [YW-1:0] y_nxt_c,
  output logic          edge_nxt_c,
  output logic          last_c
);

  logic [XW-1:0] xmin, xmax, x;
  logic [YW-1:0] ymin, ymax, y;
  logic [XW-1:0] bxmin_c, bxmax_c;
  logic [YW-1:0] bymin_c, bymax_c;

  // Next position and whether it lies on the rectangle border
  always_comb begin
    bxmin_c    = start ? xmin_in : xmin;
    bxmax_c    = start ? xmax_in : xmax;
    bymin_c    = start ? ymin_in : ymin;
    bymax_c    = start ? ymax_in : ymax;
    x_nxt_c    = x;
    y_nxt_c    = y;
    last_c     = (x == xmax) && (y == ymax);
    if (start) begin
      x_nxt_c = xmin_in;
      y_nxt_c = ymin_in;
    end else if (step) begin
      if (x == xmax) begin
        x_nxt_c = xmin;
        y_nxt_c = y + YW'(1);
      end else begin
        x_nxt_c = x + XW'(1);
      end
    end
    edge_nxt_c = (x_nxt_c == bxmin_c) || (x_nxt_c == bxmax_c) ||
                 (y_nxt_c == bymin_c) || (y_nxt_c == bymax_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
      x    <= '0;
      y    <= '0;
    end else begin
      if (start) begin
        xmin <= xmin_in;
        xmax <= xmax_in;
        ymin <= ymin_in;
        ymax <= ymax_in;
      end
      x <= x_nxt_c;
      y <= y_nxt_c;
    end
  end

endmodule

// File: rtl/paint_pixel_datapath.sv
// Corner/colour registers, draw FSM and registered pixel stream for the
// 160x120 VGA adapter: filled rectangle, outline rectangle and freeform point.
module paint_pixel_datapath
  import paint_pixel_datapath_pkg::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  paint_pixel_datapath_if.slave  bus
);

  state_t        state;
  logic [XW-1:0] x1, x2;
  logic [YW-1:0] y1, y2;
  logic [CW-1:0] colour, scan_colour;
  logic          scan_fill;
  logic          armed;
  logic          busy_q, done_q;
  pixel_t        pix;

  logic          loads_ok_c, rect_start_c, point_go_c, step_c, fill_sel_c;
  logic [XW-1:0] xmin_c, xmax_c, x1_nxt_c, x_nxt_c;
  logic [YW-1:0] ymin_c, ymax_c, y1_nxt_c, y_nxt_c;
  logic [CW-1:0] colour_nxt_c;
  logic          edge_nxt_c, last_c;

  assign bus.x_out      = pix.x;
  assign bus.y_out      = pix.y;
  assign bus.colour_out = pix.colour;
  assign bus.plot       = pix.plot;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Corner ordering, post-load point values and FSM qualifiers
  always_comb begin
    xmin_c       = (x1 < x2) ? x1 : x2;
    xmax_c       = (x1 < x2) ? x2 : x1;
    ymin_c       = (y1 < y2) ? y1 : y2;
    ymax_c       = (y1 < y2) ? y2 : y1;
    loads_ok_c   = (state == ST_IDLE) || (state == ST_POINT);
    x1_nxt_c     = x1;
    y1_nxt_c     = y1;
    colour_nxt_c = colour;
    if (loads_ok_c) begin
      if (bus.loadX) x1_nxt_c = clamp_x(bus.data_in);
      if (bus.loadY) y1_nxt_c = clamp_y(bus.data_in[YW-1:0]);
      if (bus.loadC) colour_nxt_c = bus.colour_in;
    end
    fill_sel_c   = (bus.alu_select == MODE_FILL);
    rect_start_c = (state == ST_IDLE) && bus.enable && armed &&
                   (fill_sel_c || (bus.alu_select == MODE_OUTLINE));
    point_go_c   = bus.enable && (bus.alu_select == MODE_POINT);
    step_c       = (state == ST_SCAN) && !last_c;
  end

  paint_pixel_datapath_raster_scan_counter u_scan (
    .clk        (Clock),
    .rst        (Reset),
    .start      (rect_start_c),
    .step       (step_c),
    .xmin_in    (xmin_c),
    .xmax_in    (xmax_c),
    .ymin_in    (ymin_c),
    .ymax_in    (ymax_c),
    .x_nxt_c    (x_nxt_c),
    .y_nxt_c    (y_nxt_c),
    .edge_nxt_c (edge_nxt_c),
    .last_c     (last_c)
  );

  // armed means enable was seen low in the previous cycle; cleared by reset so
  // enable held high through a reset cannot launch a draw
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      x1          <= '0;
      y1          <= '0;
      x2          <= '0;
      y2          <= '0;
      colour      <= '0;
      scan_colour <= '0;
      scan_fill   <= 1'b0;
      armed       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix         <= '0;
    end else begin
      armed  <= ~bus.enable;
      done_q <= 1'b0;
      if (loads_ok_c) begin
        x1     <= x1_nxt_c;
        y1     <= y1_nxt_c;
        colour <= colour_nxt_c;
        if (bus.loadX2) x2 <= clamp_x(bus.data_in);
        if (bus.loadY2) y2 <= clamp_y(bus.data_in[YW-1:0]);
      end
      case (state)
        ST_IDLE: begin
          pix.plot <= 1'b0;
          if (point_go_c) begin
            state      <= ST_POINT;
            pix.x      <= x1_nxt_c;
            pix.y      <= y1_nxt_c;
            pix.colour <= colour_nxt_c;
            pix.plot   <= 1'b1;
          end else if (rect_start_c) begin
            state       <= ST_SCAN;
            busy_q      <= 1'b1;
            scan_colour <= colour;
            scan_fill   <= fill_sel_c;
            pix.x       <= x_nxt_c;
            pix.y       <= y_nxt_c;
            pix.colour  <= colour;
            pix.plot    <= fill_sel_c | edge_nxt_c;
          end
        end
        ST_SCAN: begin
          if (last_c) begin
            state    <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            pix.plot <= 1'b0;
          end else begin
            pix.x      <= x_nxt_c;
            pix.y      <= y_nxt_c;
            pix.colour <= scan_colour;
            pix.plot   <= scan_fill | edge_nxt_c;
          end
        end
        ST_POINT: begin
          if (point_go_c) begin
            pix.x      <= x1_nxt_c;
            pix.y      <= y1_nxt_c;
            pix.colour <= colour_nxt_c;
            pix.plot   <= 1'b1;
          end else begin
            state    <= ST_IDLE;
            pix.plot <= 1'b0;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          pix.plot <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_pixel_datapath.sv
// Self-checking bench: rectangle table, hand-written corner sequences and
// random rectangles checked against a list-of-pixels reference model.
module tb_paint_pixel_datapath;
  import paint_pixel_datapath_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  paint_pixel_datapath_if bus ();

  paint_pixel_datapath dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Model registers, updated from the load rules
  int mx1, my1, mx2, my2, mc;

  typedef struct {
    int x;
    int y;
    bit plot;
  } mpix_t;

  typedef struct {
    int         x1, y1, x2, y2, c;
    logic [1:0] mode;
    int         cyc, plots, fx, fy, lx, ly;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int clx(input int d);
    return (d > 159) ? 159 : d;
  endfunction

  function automatic int cly(input int d);
    int v;
    v = d % 128;
    return (v > 119) ? 119 : v;
  endfunction

  task automatic clear_loads();
    bus.loadX  = 1'b0;
    bus.loadY  = 1'b0;
    bus.loadX2 = 1'b0;
    bus.loadY2 = 1'b0;
    bus.loadC  = 1'b0;
  endtask

  task automatic load_all(input int x1, input int y1, input int x2, input int y2, input int c);
    clear_loads();
    bus.enable = 1'b0;
    bus.data_in = 8'(x1); bus.loadX  = 1'b1; step(); bus.loadX  = 1'b0; mx1 = clx(x1);
    bus.data_in = 8'(y1); bus.loadY  = 1'b1; step(); bus.loadY  = 1'b0; my1 = cly(y1);
    bus.data_in = 8'(x2); bus.loadX2 = 1'b1; step(); bus.loadX2 = 1'b0; mx2 = clx(x2);
    bus.data_in = 8'(y2); bus.loadY2 = 1'b1; step(); bus.loadY2 = 1'b0; my2 = cly(y2);
    bus.colour_in = 3'(c); bus.loadC = 1'b1; step(); bus.loadC = 1'b0; mc = c;
  endtask

  // Starts a rectangle draw and follows it pixel by pixel against the model list
  task automatic draw(input logic [1:0] mode, input bit mid_load, input int hold_after,
                      output int cyc, output int plots,
                      output int fx, output int fy, output int lx, output int ly);
    mpix_t q[$];
    int xa, xb, ya, yb;
    xa = (mx1 < mx2) ? mx1 : mx2;
    xb = (mx1 < mx2) ? mx2 : mx1;
    ya = (my1 < my2) ? my1 : my2;
    yb = (my1 < my2) ? my2 : my1;
    for (int yy = ya; yy <= yb; yy++)
      for (int xx = xa; xx <= xb; xx++)
        q.push_back('{xx, yy, (mode == MODE_FILL) || xx == xa || xx == xb || yy == ya || yy == yb});
    clear_loads();
    bus.alu_select = mode;
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
    step();
    cyc = 0; plots = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    while (bus.busy === 1'b1 && cyc < 20000) begin
      if (cyc < q.size()) begin
        chk("pix_x", bus.x_out, q[cyc].x);
        chk("pix_y", bus.y_out, q[cyc].y);
        chk("pix_colour", bus.colour_out, mc);
        chk("pix_plot", bus.plot, q[cyc].plot);
        chk("pix_done", bus.done, 0);
      end
      if (cyc == 0) begin fx = bus.x_out; fy = bus.y_out; end
      lx = bus.x_out; ly = bus.y_out;
      if (bus.plot === 1'b1) plots++;
      cyc++;
      if (mid_load) begin
        bus.data_in    = 8'($urandom);
        bus.colour_in  = 3'($urandom);
        bus.loadX      = 1'($urandom);
        bus.loadY      = 1'($urandom);
        bus.loadX2     = 1'b1;
        bus.loadY2     = 1'($urandom);
        bus.loadC      = 1'($urandom);
        bus.alu_select = 2'($urandom);
      end
      step();
    end
    clear_loads();
    bus.alu_select = mode;
    chk("scan_cycles", cyc, q.size());
    chk("done_pulse", bus.done, 1);
    chk("done_plot", bus.plot, 0);
    chk("done_busy", bus.busy, 0);
    for (int i = 0; i < hold_after; i++) begin
      step();
      chk("hold_done", bus.done, 0);
      chk("hold_plot", bus.plot, 0);
      chk("hold_busy", bus.busy, 0);
    end
    bus.enable = 1'b0;
    step();
  endtask

  vec_t tbl[7];

  initial begin
    int cyc, plots, fx, fy, lx, ly;
    tbl[0] = '{10, 20, 12, 21, 4, MODE_FILL,      6,  6, 10,  20,  12,  21};
    tbl[1] = '{ 5,  5,  7,  7, 2, MODE_OUTLINE,   9,  8,  5,   5,   7,   7};
    tbl[2] = '{50,  3, 48,  3, 1, MODE_FILL,      3,  3, 48,   3,  50,   3};
    tbl[3] = '{200, 127, 150, 100, 7, MODE_OUTLINE, 200, 56, 150, 100, 159, 119};
    tbl[4] = '{ 0,  0,  0,  0, 3, MODE_FILL,      1,  1,  0,   0,   0,   0};
    tbl[5] = '{ 9,  4,  9,  8, 5, MODE_OUTLINE,   5,  5,  9,   4,   9,   8};
    tbl[6] = '{255, 255, 158, 118, 6, MODE_FILL,  4,  4, 158, 118, 159, 119};

    bus.data_in = '0; bus.colour_in = '0; bus.enable = 1'b0; bus.alu_select = MODE_NONE;
    clear_loads();
    rst = 1'b1;
    step(); step();
    chk("rst_x", bus.x_out, 0);
    chk("rst_y", bus.y_out, 0);
    chk("rst_colour", bus.colour_out, 0);
    chk("rst_plot", bus.plot, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    mx1 = 0; my1 = 0; mx2 = 0; my2 = 0; mc = 0;
    step();

    // Table of rectangles with hand-computed summaries
    foreach (tbl[i]) begin
      load_all(tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, tbl[i].c);
      draw(tbl[i].mode, 1'b0, 0, cyc, plots, fx, fy, lx, ly);
      chk("tbl_cycles", cyc, tbl[i].cyc);
      chk("tbl_plots", plots, tbl[i].plots);
      chk("tbl_first_x", fx, tbl[i].fx);
      chk("tbl_first_y", fy, tbl[i].fy);
      chk("tbl_last_x", lx, tbl[i].lx);
      chk("tbl_last_y", ly, tbl[i].ly);
    end

    // Mode none never starts
    load_all(1, 1, 3, 3, 2);
    bus.alu_select = MODE_NONE; bus.enable = 1'b0; step();
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("none_busy", bus.busy, 0);
      chk("none_plot", bus.plot, 0);
    end
    bus.enable = 1'b0; step();

    // Point mode with loads while plotting
    bus.alu_select = MODE_POINT;
    bus.data_in = 8'd30; bus.loadX = 1'b1; step(); mx1 = 30;
    bus.loadX = 1'b0; bus.enable = 1'b1; step();
    chk("pt_x0", bus.x_out, 30);
    chk("pt_y0", bus.y_out, my1);
    chk("pt_c0", bus.colour_out, mc);
    chk("pt_plot0", bus.plot, 1);
    bus.data_in = 8'd31; bus.loadX = 1'b1; step();
    chk("pt_x1", bus.x_out, 31);
    chk("pt_plot1", bus.plot, 1);
    bus.loadX = 1'b0; bus.data_in = 8'd5; bus.loadY = 1'b1; step();
    chk("pt_y2", bus.y_out, 5);
    chk("pt_x2", bus.x_out, 31);
    bus.loadY = 1'b0; bus.enable = 1'b0; step();
    chk("pt_off_plot", bus.plot, 0);
    chk("pt_off_done", bus.done, 0);
    chk("pt_off_busy", bus.busy, 0);
    step();
    chk("pt_hold_x", bus.x_out, 31);
    bus.enable = 1'b1; step();
    chk("pt_re_plot", bus.plot, 1);
    bus.alu_select = MODE_FILL; step();
    chk("pt_sel_plot", bus.plot, 0);
    step();
    chk("pt_sel_busy", bus.busy, 0);
    bus.enable = 1'b0; step();
    my1 = 5;

    // Reset on the third pixel of a 4x4 fill, enable kept high afterwards
    load_all(20, 40, 23, 43, 6);
    bus.alu_select = MODE_FILL; bus.enable = 1'b0; step();
    bus.enable = 1'b1; step(); step(); step();
    chk("rst3_x", bus.x_out, 22);
    chk("rst3_busy", bus.busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    mx1 = 0; my1 = 0; mx2 = 0; my2 = 0; mc = 0;
    chk("rstmid_plot", bus.plot, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_done", bus.done, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstmid_norestart_plot", bus.plot, 0);
      chk("rstmid_norestart_busy", bus.busy, 0);
      chk("rstmid_norestart_done", bus.done, 0);
    end
    bus.enable = 1'b0; step();

    // Loads during scan are ignored; enable held across done does not restart
    load_all(60, 70, 62, 71, 6);
    draw(MODE_FILL, 1'b1, 5, cyc, plots, fx, fy, lx, ly);
    chk("midload_cycles", cyc, 6);
    chk("midload_plots", plots, 6);
    draw(MODE_OUTLINE, 1'b0, 0, cyc, plots, fx, fy, lx, ly);
    chk("redraw_cycles", cyc, 6);
    chk("redraw_plots", plots, 6);
    chk("redraw_last_x", lx, 62);
    chk("redraw_last_y", ly, 71);

    // Random rectangles, including clamped and swapped corners
    for (int n = 0; n < 25; n++) begin
      int x1d, x2d, y1d, y2d, w, h, ep;
      logic [1:0] m;
      x1d = $urandom_range(0, 255);
      x2d = $urandom_range(0, 1) ? x1d + $urandom_range(0, 6) : x1d - $urandom_range(0, 6);
      y1d = $urandom_range(0, 255);
      y2d = $urandom_range(0, 1) ? y1d + $urandom_range(0, 5) : y1d - $urandom_range(0, 5);
      x2d = (x2d < 0) ? 0 : (x2d > 255) ? 255 : x2d;
      y2d = (y2d < 0) ? 0 : (y2d > 255) ? 255 : y2d;
      m = $urandom_range(0, 1) ? MODE_FILL : MODE_OUTLINE;
      load_all(x1d, y1d, x2d, y2d, $urandom_range(0, 7));
      w = ((mx1 > mx2) ? mx1 - mx2 : mx2 - mx1) + 1;
      h = ((my1 > my2) ? my1 - my2 : my2 - my1) + 1;
      ep = (m == MODE_FILL || w == 1 || h == 1) ? w * h : 2 * w + 2 * h - 4;
      draw(m, 1'($urandom), $urandom_range(0, 2), cyc, plots, fx, fy, lx, ly);
      chk("rnd_cycles", cyc, w * h);
      chk("rnd_plots", plots, ep);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
